// File: rtl/tl45_pkg.sv
// Shared decode-stage definitions: opcode/condition constants, instruction field
// positions, the decoded-slot record and the redirect FSM states.
package tl45_pkg;

    localparam logic [4:0] OP_JMP      = 5'd12;
    localparam logic [3:0] COND_ALWAYS = 4'hF;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int FLG_MSB = 26;
    localparam int FLG_LSB = 24;
    localparam int RD_MSB  = 23;
    localparam int RD_LSB  = 20;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 16;
    localparam int RS2_MSB = 15;
    localparam int RS2_LSB = 12;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int FLAG_H  = 1;
    localparam int FLAG_Z  = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  opcode;
        logic [2:0]  flags;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] imm32;
    } dec_inst_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDIR  = 2'd1,
        SQUASH = 2'd2
    } dec_state_t;

endpackage

// File: rtl/tl45_decode_if.sv
// Fetch-buffer, pipeline-control and decode-result bundle between fetch, decode and execute.
interface tl45_decode_if;
    import tl45_pkg::*;

    logic        i_pipe_stall;
    logic        i_pipe_flush;
    logic [31:0] i_buf_pc;
    logic [31:0] i_buf_inst;
    logic        o_new_pc;
    logic [31:0] o_pc;
    logic        o_dr_valid;
    logic [31:0] o_dr_pc;
    logic [4:0]  o_dr_opcode;
    logic [2:0]  o_dr_flags;
    logic [3:0]  o_dr_rd;
    logic [3:0]  o_dr_rs1;
    logic [3:0]  o_dr_rs2;
    logic [31:0] o_dr_imm32;

    modport master (
        output i_pipe_stall, i_pipe_flush, i_buf_pc, i_buf_inst,
        input  o_new_pc, o_pc, o_dr_valid, o_dr_pc, o_dr_opcode, o_dr_flags,
               o_dr_rd, o_dr_rs1, o_dr_rs2, o_dr_imm32
    );

    modport slave (
        input  i_pipe_stall, i_pipe_flush, i_buf_pc, i_buf_inst,
        output o_new_pc, o_pc, o_dr_valid, o_dr_pc, o_dr_opcode, o_dr_flags,
               o_dr_rd, o_dr_rs1, o_dr_rs2, o_dr_imm32
    );
endinterface

// File: rtl/tl45_imm_gen.sv
// Immediate expansion: upper-half placement, zero-extension or sign-extension of imm16.
module tl45_imm_gen
    import tl45_pkg::*;
(
    input  logic [15:0] i_imm16,
    input  logic [1:0]  i_hz,
    output logic [31:0] o_imm32
);

    // H takes precedence over Z; neither set means signed.
    always_comb begin
        o_imm32 = 32'h0000_0000;
        if (i_hz[FLAG_H]) begin
            o_imm32 = {i_imm16, 16'h0000};
        end else if (i_hz[FLAG_Z]) begin
            o_imm32 = {16'h0000, i_imm16};
        end else begin
            o_imm32 = {{16{i_imm16[15]}}, i_imm16};
        end
    end

endmodule

// File: rtl/tl45_decode.sv
// Decode stage: registers decoded fields for execute, resolves unconditional absolute
// JMPs locally and squashes the wrong-path slots fetched behind the redirect.
module tl45_decode
    import tl45_pkg::*;
#(
    parameter int SQUASH_SLOTS = 2,
    parameter bit RESOLVE_JMP  = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    tl45_decode_if.slave  dec_if
);

    localparam int CNT_W = (SQUASH_SLOTS < 2) ? 1 : $clog2(SQUASH_SLOTS + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SQUASH_SLOTS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    dec_state_t       r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_new_pc, w_new_pc_nx;
    logic [31:0]      r_pc, w_pc_nx;
    dec_inst_t        r_dr, w_dr_nx;
    dec_inst_t        w_dec;
    logic [31:0]      w_imm32;
    logic             w_is_jmp;

    tl45_imm_gen u_imm_gen (
        .i_imm16 (dec_if.i_buf_inst[IMM_MSB:IMM_LSB]),
        .i_hz    (dec_if.i_buf_inst[FLG_LSB+1:FLG_LSB]),
        .o_imm32 (w_imm32)
    );

    // Field extraction of the buffer slot; a bubble decodes to an all-zero record.
    always_comb begin
        w_dec        = '0;
        w_dec.valid  = (dec_if.i_buf_inst != 32'h0000_0000);
        w_dec.pc     = dec_if.i_buf_pc;
        w_dec.opcode = dec_if.i_buf_inst[OPC_MSB:OPC_LSB];
        w_dec.flags  = dec_if.i_buf_inst[FLG_MSB:FLG_LSB];
        w_dec.rd     = dec_if.i_buf_inst[RD_MSB:RD_LSB];
        w_dec.rs1    = dec_if.i_buf_inst[RS1_MSB:RS1_LSB];
        w_dec.rs2    = dec_if.i_buf_inst[RS2_MSB:RS2_LSB];
        w_dec.imm32  = w_imm32;
        if (!w_dec.valid) begin
            w_dec = '0;
        end else begin
            w_dec = w_dec;
        end
        w_is_jmp = RESOLVE_JMP && w_dec.valid && (w_dec.opcode == OP_JMP)
                   && (w_dec.rd == COND_ALWAYS) && (w_dec.rs1 == 4'h0);
    end

    // Next-state logic: flush beats stall beats normal progress.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_new_pc_nx = r_new_pc;
        w_pc_nx     = r_pc;
        w_dr_nx     = r_dr;
        if (dec_if.i_pipe_flush) begin
            w_state_nx  = IDLE;
            w_cnt_nx    = '0;
            w_new_pc_nx = 1'b0;
            w_dr_nx     = '0;
        end else if (dec_if.i_pipe_stall) begin
            w_state_nx  = r_state;
            w_new_pc_nx = r_new_pc;
        end else begin
            case (r_state)
                IDLE: begin
                    w_dr_nx = w_dec;
                    if (w_is_jmp) begin
                        w_new_pc_nx = 1'b1;
                        w_pc_nx     = w_dec.imm32;
                        w_state_nx  = REDIR;
                    end else begin
                        w_new_pc_nx = 1'b0;
                    end
                end
                // Fetch takes the override on this edge; the slot it brings is wrong-path.
                REDIR: begin
                    w_dr_nx     = '0;
                    w_new_pc_nx = 1'b0;
                    w_cnt_nx    = CNT_RELOAD;
                    w_state_nx  = (CNT_RELOAD == '0) ? IDLE : SQUASH;
                end
                SQUASH: begin
                    w_dr_nx    = '0;
                    w_cnt_nx   = r_cnt - CNT_ONE;
                    w_state_nx = (r_cnt <= CNT_ONE) ? IDLE : SQUASH;
                end
                default: begin
                    w_dr_nx     = '0;
                    w_new_pc_nx = 1'b0;
                    w_cnt_nx    = '0;
                    w_state_nx  = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_new_pc <= 1'b0;
            r_pc     <= 32'h0000_0000;
            r_dr     <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_new_pc <= w_new_pc_nx;
            r_pc     <= w_pc_nx;
            r_dr     <= w_dr_nx;
        end
    end

    assign dec_if.o_new_pc    = r_new_pc;
    assign dec_if.o_pc        = r_pc;
    assign dec_if.o_dr_valid  = r_dr.valid;
    assign dec_if.o_dr_pc     = r_dr.pc;
    assign dec_if.o_dr_opcode = r_dr.opcode;
    assign dec_if.o_dr_flags  = r_dr.flags;
    assign dec_if.o_dr_rd     = r_dr.rd;
    assign dec_if.o_dr_rs1    = r_dr.rs1;
    assign dec_if.o_dr_rs2    = r_dr.rs2;
    assign dec_if.o_dr_imm32  = r_dr.imm32;

endmodule

// File: tb/tb_tl45_decode.sv
// Directed-vector bench for tl45_decode: field decode, immediates, JMP redirect/squash,
// stall hold, flush and asynchronous reset.
module tb_tl45_decode;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    tl45_decode_if dec_if ();

    tl45_decode #(.SQUASH_SLOTS(2), .RESOLVE_JMP(1'b1)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .dec_if    (dec_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
        dec_if.i_buf_pc   = pc;
        dec_if.i_buf_inst = inst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic valid, input logic [31:0] pc,
                            input logic [4:0] opc, input logic [31:0] imm, input logic new_pc);
        check_eq({tag, ".valid"},  32'(dec_if.o_dr_valid),  32'(valid));
        check_eq({tag, ".pc"},     dec_if.o_dr_pc,          pc);
        check_eq({tag, ".opcode"}, 32'(dec_if.o_dr_opcode), 32'(opc));
        check_eq({tag, ".imm32"},  dec_if.o_dr_imm32,       imm);
        check_eq({tag, ".new_pc"}, 32'(dec_if.o_new_pc),    32'(new_pc));
    endtask

    initial begin
        dec_if.i_pipe_stall = 1'b0;
        dec_if.i_pipe_flush = 1'b0;
        drive(32'h0, 32'h0);
        #12;
        chk_slot("reset", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        check_eq("reset.o_pc", dec_if.o_pc, 32'h0);
        #1 rst_n = 1'b1;

        // Field decode and immediate forms.
        drive(32'h0, 32'h0d10_6969); tick();
        chk_slot("t1", 1'b1, 32'h0, 5'd1, 32'h0000_6969, 1'b0);
        check_eq("t1.flags", 32'(dec_if.o_dr_flags), 32'd5);
        check_eq("t1.rd",    32'(dec_if.o_dr_rd),    32'd1);
        check_eq("t1.rs1",   32'(dec_if.o_dr_rs1),   32'd0);
        drive(32'h4, 32'hA910_4242); tick();
        chk_slot("t2a", 1'b1, 32'h4, 5'd21, 32'h0000_4242, 1'b0);
        check_eq("t2a.rd",  32'(dec_if.o_dr_rd),  32'd1);
        check_eq("t2a.rs2", 32'(dec_if.o_dr_rs2), 32'd4);
        drive(32'h8, 32'h0C10_8000); tick();
        chk_slot("t2b", 1'b1, 32'h8, 5'd1, 32'hFFFF_8000, 1'b0);
        drive(32'hC, 32'h0E10_1234); tick();
        chk_slot("t2c", 1'b1, 32'hC, 5'd1, 32'h1234_0000, 1'b0);
        drive(32'h10, 32'h0); tick();
        chk_slot("bubble", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0);

        // JMP 0 with two squashed slots.
        drive(32'h4, 32'h65F0_0000); tick();
        chk_slot("t3.jmp", 1'b1, 32'h4, 5'd12, 32'h0, 1'b1);
        check_eq("t3.rd",   32'(dec_if.o_dr_rd), 32'hF);
        check_eq("t3.o_pc", dec_if.o_pc,        32'h0);
        drive(32'h8, 32'h0d10_6969); tick();
        chk_slot("t3.sq8", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        drive(32'hC, 32'h0d10_6969); tick();
        chk_slot("t3.sq12", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        drive(32'h0, 32'h0d10_6969); tick();
        chk_slot("t3.tgt", 1'b1, 32'h0, 5'd1, 32'h0000_6969, 1'b0);

        // Stall held three cycles while the redirect is pending.
        drive(32'h20, 32'h65F0_0100); tick();
        chk_slot("t4.jmp", 1'b1, 32'h20, 5'd12, 32'h100, 1'b1);
        check_eq("t4.o_pc", dec_if.o_pc, 32'h100);
        dec_if.i_pipe_stall = 1'b1;
        drive(32'h24, 32'hA910_4242);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_slot($sformatf("t4.stall%0d", i), 1'b1, 32'h20, 5'd12, 32'h100, 1'b1);
        end
        dec_if.i_pipe_stall = 1'b0;
        tick();
        chk_slot("t4.sq1", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        drive(32'h28, 32'hA910_4242); tick();
        chk_slot("t4.sq2", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        drive(32'h100, 32'h0C10_8000); tick();
        chk_slot("t4.tgt", 1'b1, 32'h100, 5'd1, 32'hFFFF_8000, 1'b0);

        // Flush while squashing clears the pending squash.
        drive(32'h40, 32'h65F0_0200); tick();
        chk_slot("t5.jmp", 1'b1, 32'h40, 5'd12, 32'h200, 1'b1);
        drive(32'h44, 32'h0E10_1234); tick();
        chk_slot("t5.sq1", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        dec_if.i_pipe_flush = 1'b1;
        drive(32'h48, 32'h0E10_1234); tick();
        chk_slot("t5.flush", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        dec_if.i_pipe_flush = 1'b0;
        drive(32'h4C, 32'h0E10_1234); tick();
        chk_slot("t5.after", 1'b1, 32'h4C, 5'd1, 32'h1234_0000, 1'b0);

        // Asynchronous reset in the middle of a redirect.
        drive(32'h60, 32'h65F0_0300); tick();
        chk_slot("t6.jmp", 1'b1, 32'h60, 5'd12, 32'h300, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_slot("t6.rst", 1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        check_eq("t6.o_pc", dec_if.o_pc, 32'h0);
        #1 rst_n = 1'b1;
        drive(32'h64, 32'h65E0_0000); tick();
        chk_slot("t6.jcc", 1'b1, 32'h64, 5'd12, 32'h0, 1'b0);
        check_eq("t6.rd", 32'(dec_if.o_dr_rd), 32'hE);
        drive(32'h68, 32'h0d10_6969); tick();
        chk_slot("t6.next", 1'b1, 32'h68, 5'd1, 32'h0000_6969, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
